div_share_ctrl: RTL

//  Shares one iterative 16-bit unsigned non-restoring divider among NUM_REQ requesters.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_nr_core.sv | 65 ++++++
 rtl/div_share_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the time-shared iterative divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam int DEF_WIDTH   = 16;
   localparam int DEF_NUM_REQ = 4;
   localparam int MIN_NUM_REQ = 2;
   localparam int MAX_NUM_REQ = 8;

   function automatic int step_cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/div_nr_core.sv
// Non-restoring divide datapath: one quotient bit per step, optional final
// remainder correction. Sequencing is owned by the controller.
module div_nr_core
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             step_i,
   input  logic             fix_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             sign_o
);

   logic [WIDTH:0]   a_q, a_d;
   logic [WIDTH:0]   m_q, m_d;
   logic [WIDTH:0]   shift_s;
   logic [WIDTH-1:0] q_q, q_d;

   // Shift/add-subtract wraps modulo 2^(WIDTH+1); the post-step value always fits.
   always_comb begin
      shift_s = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
      a_d     = a_q;
      q_d     = q_q;
      m_d     = m_q;
      if (load_i) begin
         a_d = '0;
         q_d = dividend_i;
         m_d = {1'b0, divisor_i};
      end else if (step_i) begin
         if (a_q[WIDTH]) begin
            a_d = shift_s + m_q;
         end else begin
            a_d = shift_s - m_q;
         end
         q_d = {q_q[WIDTH-2:0], ~a_d[WIDTH]};
      end else if (fix_i) begin
         a_d = a_q + m_q;
      end else begin
         a_d = a_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q <= '0;
         q_q <= '0;
         m_q <= '0;
      end else begin
         a_q <= a_d;
         q_q <= q_d;
         m_q <= m_d;
      end
   end

   assign quotient_o  = q_q;
   assign remainder_o = a_q[WIDTH-1:0];
   assign sign_o      = a_q[WIDTH];

endmodule

// File: rtl/div_share_ctrl.sv
// Round-robin front end sharing one iterative divider among NUM_REQ clients,
// with a single id-tagged response port.
module div_share_ctrl
   import div_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   localparam int IDW    = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_dividend,
   input  logic [NUM_REQ*WIDTH-1:0] req_divisor,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [WIDTH-1:0]         rsp_quotient,
   output logic [WIDTH-1:0]         rsp_remainder,
   output logic                     rsp_div_zero,
   output logic                     busy
);

   localparam int CNT_W = step_cnt_w(WIDTH);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [IDW-1:0]     rr_q, rr_d;
   logic [IDW-1:0]     id_q;
   logic               dz_q;
   logic               rsp_valid_q;
   logic [IDW-1:0]     rsp_id_q;
   logic [WIDTH-1:0]   rsp_quot_q;
   logic [WIDTH-1:0]   rsp_rem_q;
   logic               rsp_dz_q;

   logic               found_s;
   logic               accept_s;
   logic [IDW-1:0]     gnt_idx_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [WIDTH-1:0]   sel_dividend_s;
   logic [WIDTH-1:0]   sel_divisor_s;
   logic               div_zero_s;
   logic [WIDTH-1:0]   core_quot_s;
   logic [WIDTH-1:0]   core_rem_s;
   logic               core_sign_s;

   function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) begin
         s = s - NUM_REQ;
      end
      return IDW'(s);
   endfunction

   // First valid requester at or after the rr pointer wins; grants only in IDLE.
   always_comb begin
      found_s   = 1'b0;
      gnt_idx_s = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found_s && req_valid[rr_idx(rr_q, k)]) begin
            found_s   = 1'b1;
            gnt_idx_s = rr_idx(rr_q, k);
         end else begin
            found_s = found_s;
         end
      end
      accept_s = found_s && (state_q == IDLE) && !rst;
      grant_s  = '0;
      if (accept_s) begin
         grant_s[gnt_idx_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
      rr_d = (gnt_idx_s == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx_s + 1'b1;
   end

   assign sel_dividend_s = req_dividend[gnt_idx_s*WIDTH +: WIDTH];
   assign sel_divisor_s  = req_divisor[gnt_idx_s*WIDTH +: WIDTH];
   assign div_zero_s     = (sel_divisor_s == '0);

   div_nr_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk         (clk),
      .rst         (rst),
      .load_i      (accept_s),
      .step_i      (state_q == ITER),
      .fix_i       ((state_q == FIX) && core_sign_s),
      .dividend_i  (sel_dividend_s),
      .divisor_i   (sel_divisor_s),
      .quotient_o  (core_quot_s),
      .remainder_o (core_rem_s),
      .sign_o      (core_sign_s)
   );

   // Response registers load once on the first RESP cycle, then hold until handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rr_q        <= '0;
         id_q        <= '0;
         dz_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_quot_q  <= '0;
         rsp_rem_q   <= '0;
         rsp_dz_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s) begin
                  id_q    <= gnt_idx_s;
                  rr_q    <= rr_d;
                  cnt_q   <= '0;
                  dz_q    <= div_zero_s;
                  state_q <= div_zero_s ? RESP : ITER;
               end
            end
            ITER: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  state_q <= FIX;
               end
            end
            FIX: begin
               state_q <= RESP;
            end
            RESP: begin
               if (!rsp_valid_q) begin
                  rsp_valid_q <= 1'b1;
                  rsp_id_q    <= id_q;
                  rsp_quot_q  <= dz_q ? '1 : core_quot_s;
                  rsp_rem_q   <= dz_q ? core_quot_s : core_rem_s;
                  rsp_dz_q    <= dz_q;
               end else if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req_ready     = grant_s;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_id        = rsp_id_q;
   assign rsp_quotient  = rsp_quot_q;
   assign rsp_remainder = rsp_rem_q;
   assign rsp_div_zero  = rsp_dz_q;
   assign busy          = (state_q != IDLE);

endmodule
